// File: rtl/jtpang_objdma.sv
// jtpang_objdma: sprite-table DMA engine.
// On a rising edge of dma_go it requests the Z80 bus and copies the whole
// 2**AW-byte VRAM window, in ascending order, into the object attribute
// buffer. The copy is paced by pxl_cen. When it is done, the bus is released
// and done pulses.
//
// Optional feature (macro JTPANG_OBJDMA_TIMEOUT_EN): abort the request when
// the bus grant has not arrived after TOUT pxl_cen ticks. The abort sets the
// sticky timeout flag. Without the macro, REQ waits forever and timeout is 0.
//
// Ports:
//   clk, rst_n     48 MHz video clock, async active-low reset
//   pxl_cen        8 MHz enable; the FSM and datapath advance only on it
//   dma_go         transfer trigger level (rising edge, sampled every clk)
//   busak_n        Z80 bus acknowledge, active low
//   busrq          Z80 bus request
//   dma_addr       VRAM read address; dma_din returns data one clk later
//   buf_addr/din   object buffer write address / data
//   buf_we         object buffer write strobe, one clk wide
//   busy           trigger accepted until bus released
//   done           one-clk pulse after a completed transfer
//   timeout        sticky grant-timeout flag
module jtpang_objdma #(
  parameter int unsigned AW   = 9,
  parameter int unsigned TOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_REL
  } state_e;

  state_e        state_q, state_d;
  logic          go_q;
  logic          pend_q, pend_d;
  logic          busrq_q, busrq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic [AW-1:0] dma_addr_q, dma_addr_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_din_q, buf_din_d;
  logic          go_rise;

`ifdef JTPANG_OBJDMA_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;
`endif

  // Edge detect runs every clk so short CPU pulses between enables are caught.
  assign go_rise = dma_go & ~go_q;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | go_rise;
    busrq_d    = busrq_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    dma_addr_d = dma_addr_q;
    buf_addr_d = buf_addr_q;
    buf_din_d  = buf_din_q;
`ifdef JTPANG_OBJDMA_TIMEOUT_EN
    cnt_d      = cnt_q;
    tout_d     = tout_q;
`endif
    if (pxl_cen) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            // An edge arriving on this very clk stays pending for the next run.
            pend_d  = go_rise;
            busrq_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_REQ;
`ifdef JTPANG_OBJDMA_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        ST_REQ: begin
          if (!busak_n) begin
            dma_addr_d = '0;
            state_d    = ST_XFER;
          end
`ifdef JTPANG_OBJDMA_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            busrq_d = 1'b0;
            busy_d  = 1'b0;
            tout_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        ST_XFER: begin
          // A withdrawn grant freezes the walk in place.
          if (!busak_n) begin
            buf_addr_d = dma_addr_q;
            buf_din_d  = dma_din;
            we_d       = 1'b1;
            dma_addr_d = dma_addr_q + AW'(1);
            if (dma_addr_q == LAST_ADDR) state_d = ST_REL;
          end
        end
        ST_REL: begin
          busrq_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      go_q       <= 1'b0;
      pend_q     <= 1'b0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      dma_addr_q <= '0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
`ifdef JTPANG_OBJDMA_TIMEOUT_EN
      cnt_q      <= '0;
      tout_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      go_q       <= dma_go;
      pend_q     <= pend_d;
      busrq_q    <= busrq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      dma_addr_q <= dma_addr_d;
      buf_addr_q <= buf_addr_d;
      buf_din_q  <= buf_din_d;
`ifdef JTPANG_OBJDMA_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
`endif
    end
  end

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign buf_we   = we_q;
  assign dma_addr = dma_addr_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;

`ifdef JTPANG_OBJDMA_TIMEOUT_EN
  assign timeout = tout_q;
`else
  // TOUT only matters with the grant timeout built in.
  localparam logic TOUT_NONZERO = (TOUT != 0);
  assign timeout = 1'b0 & TOUT_NONZERO;
`endif

endmodule

// File: tb/tb_jtpang_objdma.sv
module tb_jtpang_objdma;

`ifdef JTPANG_OBJDMA_TIMEOUT_EN
  localparam int unsigned TB_TOUT = 16;
`else
  localparam int unsigned TB_TOUT = 4096;
`endif
  localparam int unsigned N = 512;

  logic       clk, rst_n, pxl_cen, dma_go, busak_n;
  logic       busrq, buf_we, busy, done, timeout;
  logic [8:0] dma_addr, buf_addr;
  logic [7:0] dma_din, buf_din;

  jtpang_objdma #(.AW(9), .TOUT(TB_TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .dma_go(dma_go),
    .busak_n(busak_n), .busrq(busrq), .dma_addr(dma_addr), .dma_din(dma_din),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .busy(busy),
    .done(done), .timeout(timeout)
  );

  typedef struct {
    int unsigned wait_t;
    int unsigned div;
    int unsigned drop_at;
    int unsigned drop_len;
    bit          retrig;
    bit          pat5a;
    int unsigned exp_wr;
    int unsigned exp_done;
    int unsigned exp_ticks;
  } scn_t;

  // Main-process controls
  logic [7:0]  mem [N];
  int unsigned grant_wait, cen_div, drop_at, drop_len;
  bit          cen_hold;
  int          scn_id;
  bit          exp_tout;
  int unsigned n_cmp, n_bad;

  // Driver-owned state
  bit          was_tick;
  int unsigned div_cnt, hold_cnt, drop_left;
  int          drop_used;
  logic [8:0]  rd_addr;

  // Monitor-owned state
  logic [8:0]  wa_q [$];
  logic [7:0]  wd_q [$];
  int unsigned done_cnt, rq_ticks, we_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel enable divider, VRAM read port and a Z80 bus-arbiter model.
  initial begin
    pxl_cen = 1'b0; busak_n = 1'b1; dma_din = '0; rd_addr = '0;
    div_cnt = 0; hold_cnt = 0; drop_left = 0; drop_used = -1;
    forever begin
      @(posedge clk);
      was_tick = pxl_cen;
      #1;
      dma_din = mem[rd_addr];
      rd_addr = dma_addr;
      if (!rst_n) begin
        hold_cnt = 0; drop_left = 0; busak_n = 1'b1;
      end else if (was_tick) begin
        if (drop_left > 0) drop_left--;
        hold_cnt = busrq ? hold_cnt + 1 : 0;
        if (busrq && drop_len > 0 && drop_used != scn_id && dma_addr == 9'(drop_at)) begin
          drop_left = drop_len;
          drop_used = scn_id;
        end
        busak_n = !(busrq && hold_cnt > grant_wait && drop_left == 0);
      end
      if (cen_hold) pxl_cen = 1'b0;
      else begin
        div_cnt = (div_cnt + 1 >= cen_div) ? 0 : div_cnt + 1;
        pxl_cen = (div_cnt == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (buf_we) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_din);
      if (!busy) we_bad++;
    end
    if (done) done_cnt++;
    if (pxl_cen && busrq) rq_ticks++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: entry k of a run is buffer address k mod 512 holding mem[k mod 512].
  task automatic chk_log(input string nm, input int unsigned base, input int unsigned cnt);
    int bad = -1;
    for (int k = 0; k < int'(cnt) && base + k < wa_q.size(); k++) begin
      if (wa_q[base + k] !== 9'(k % N) || wd_q[base + k] !== mem[k % N]) begin
        bad = k;
        break;
      end
    end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s log: entry %0d got addr %0d data %02h expected addr %0d data %02h",
               nm, bad, wa_q[base + bad], wd_q[base + bad], bad % N, mem[bad % N]);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++; n_bad++;
    $display("FAIL %s: wait expired", nm);
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 dma_go = 1'b1;
    repeat (2) @(posedge clk);
    #1 dma_go = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_addr(input int unsigned a, input string nm);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (!(busy && dma_addr == 9'(a)) && n < 40000);
    if (!(busy && dma_addr == 9'(a))) timeout_fail({nm, " addr"});
  endtask

  task automatic wait_done_sig(input string nm);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40000);
    if (!done) timeout_fail({nm, " done"});
  endtask

  task automatic wait_cnt(input int unsigned target, input int unsigned budget, input string nm);
    int unsigned n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
    if (done_cnt < target) timeout_fail({nm, " done count"});
  endtask

  task automatic fill_mem(input bit pat5a);
    for (int i = 0; i < int'(N); i++) mem[i] = pat5a ? (8'(i) ^ 8'h5A) : 8'($urandom);
  endtask

  task automatic setup(input int unsigned w, input int unsigned d, input int unsigned da, input int unsigned dl);
    grant_wait = w; cen_div = d; drop_at = da; drop_len = dl; scn_id++;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int unsigned wb, db, tb0, cnt;
    string nm;
    nm = $sformatf("scn%0d", idx);
    fill_mem(s.pat5a);
    setup(s.wait_t, s.div, s.drop_at, s.drop_len);
    wb = wa_q.size(); db = done_cnt; tb0 = rq_ticks;
    pulse_go();
    if (s.retrig) begin
      wait_addr(50, nm);
      pulse_go();
      pulse_go();
      wait_done_sig(nm);
      cnt = 0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (busrq) break;
        if (pxl_cen) cnt++;
      end
      chk({nm, " restart ticks"}, cnt, 1);
    end
    wait_cnt(db + s.exp_done, s.exp_done * (s.wait_t + s.drop_len + 600) * s.div + 1000, nm);
    repeat (4 * s.div) @(negedge clk);
    chk({nm, " writes"}, wa_q.size() - wb, s.exp_wr);
    chk_log(nm, wb, s.exp_wr);
    chk({nm, " dones"}, done_cnt - db, s.exp_done);
    chk({nm, " busrq ticks"}, rq_ticks - tb0, s.exp_ticks);
    chk({nm, " busrq end"}, busrq, 0);
    chk({nm, " busy end"}, busy, 0);
    chk({nm, " timeout"}, timeout, exp_tout);
    chk({nm, " stray we"}, we_bad, 0);
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scn_t scn[7];
    int unsigned w, wb;
    logic [31:0] v;

    n_cmp = 0; n_bad = 0; scn_id = 0; exp_tout = 1'b0; cen_hold = 1'b0;
    grant_wait = 3; cen_div = 6; drop_at = 0; drop_len = 0;
    for (int i = 0; i < int'(N); i++) mem[i] = '0;
    dma_go = 1'b0; rst_n = 1'b1;

    //        wait div drop  len rtg p5a  wr    done ticks
    scn[0] = '{3,   6,  0,    0,  0,  1,  512,  1,   517};
    scn[1] = '{3,   6,  100,  10, 0,  0,  512,  1,   527};
    scn[2] = '{0,   6,  0,    0,  1,  0,  1024, 2,   1028};
    scn[3] = '{5,   2,  0,    0,  0,  0,  512,  1,   519};
    for (int i = 4; i < 7; i++) begin
      w = $urandom_range(0, 9);
      scn[i].wait_t = w;
      scn[i].div = $urandom_range(2, 6);
      scn[i].drop_at = $urandom_range(1, 500);
      scn[i].drop_len = $urandom_range(0, 12);
      scn[i].retrig = 1'b0;
      scn[i].pat5a = 1'b0;
      scn[i].exp_wr = N;
      scn[i].exp_done = 1;
      scn[i].exp_ticks = w + N + 2 + scn[i].drop_len;
    end

    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst busrq", busrq, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst timeout", timeout, 0);
    chk("rst buf_we", buf_we, 0);
    v = 32'(dma_addr); chk("rst dma_addr", v, 0);
    v = 32'(buf_addr); chk("rst buf_addr", v, 0);
    v = 32'(buf_din);  chk("rst buf_din", v, 0);
    repeat (60) @(negedge clk);
    chk("idle no go busrq", busrq, 0);

    for (int i = 0; i < 7; i++) run_scn(i, scn[i]);

    // Reset in the middle of a transfer.
    fill_mem(1'b0);
    setup(1, 6, 0, 0);
    wb = wa_q.size();
    pulse_go();
    wait_addr(300, "midrst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busrq", busrq, 0);
    chk("midrst busy", busy, 0);
    chk("midrst buf_we", buf_we, 0);
    chk("midrst done", done, 0);
    chk("midrst timeout", timeout, 0);
    v = 32'(dma_addr); chk("midrst dma_addr", v, 0);
    v = 32'(buf_addr); chk("midrst buf_addr", v, 0);
    v = 32'(buf_din);  chk("midrst buf_din", v, 0);
    chk("midrst partial writes", wa_q.size() - wb, 300);
    chk_log("midrst", wb, 300);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wb = wa_q.size();
    repeat (120) @(negedge clk);
    chk("post-rst busrq", busrq, 0);
    chk("post-rst busy", busy, 0);
    chk("post-rst writes", wa_q.size() - wb, 0);

    // Freeze pxl_cen mid-transfer.
    begin
      int unsigned db, we_seen;
      fill_mem(1'b0);
      setup(2, 6, 0, 0);
      wb = wa_q.size(); db = done_cnt;
      pulse_go();
      wait_addr(200, "gate");
      cen_hold = 1'b1;
      we_seen = 0;
      repeat (100) begin
        @(negedge clk);
        if (buf_we) we_seen++;
      end
      v = 32'(dma_addr); chk("gate dma_addr", v, 200);
      chk("gate buf_we", we_seen, 0);
      chk("gate busy", busy, 1);
      chk("gate writes", wa_q.size() - wb, 200);
      cen_hold = 1'b0;
      wait_cnt(db + 1, 5000, "gate");
      repeat (24) @(negedge clk);
      chk("gate total writes", wa_q.size() - wb, N);
      chk_log("gate", wb, N);
      chk("gate dones", done_cnt - db, 1);
    end

`ifdef JTPANG_OBJDMA_TIMEOUT_EN
    // Grant never arrives: abort after TB_TOUT ticks in REQ.
    begin
      int unsigned db, tb0, n;
      setup(1_000_000, 6, 0, 0);
      wb = wa_q.size(); db = done_cnt; tb0 = rq_ticks;
      pulse_go();
      n = 0;
      while (!busrq && n < 200) begin @(negedge clk); n++; end
      if (!busrq) timeout_fail("tout req");
      n = 0;
      while (busrq && n < 2000) begin @(negedge clk); n++; end
      if (busrq) timeout_fail("tout drop");
      repeat (12) @(negedge clk);
      chk("tout busrq ticks", rq_ticks - tb0, TB_TOUT);
      chk("tout flag", timeout, 1);
      chk("tout busy", busy, 0);
      chk("tout writes", wa_q.size() - wb, 0);
      chk("tout dones", done_cnt - db, 0);
      exp_tout = 1'b1;
      run_scn(9, '{2, 6, 0, 0, 0, 0, 512, 1, 516});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtpang_objdma.md
Name: jtpang_objdma

Overview:
Sprite-table DMA engine feeding the object line engine inside the video subsystem. On a CPU-issued dma_go it requests the Z80 bus and walks all 512 bytes of the shared VRAM window. Each byte is copied into the object attribute buffer that the sprite renderer scans every line, and the bus is then released. The transfer is paced by the 8 MHz pixel clock enable and runs on the 48 MHz video clock.

Parameters:
AW, 9, address width; transfer length is 2**AW bytes
TOUT, 4096, pxl_cen ticks to wait for bus grant before abort (used only with the optional feature)

Ports:
clk       in   1   48 MHz video clock
rst_n     in   1   asynchronous active-low reset
pxl_cen   in   1   8 MHz clock enable; all state advances only when high
dma_go    in   1   CPU DMA trigger level; rising edge starts a transfer
busak_n   in   1   Z80 bus acknowledge, active low
busrq     out  1   Z80 bus request, active high
dma_addr  out  AW  VRAM read address during transfer
dma_din   in   8   VRAM read data, valid one clk after dma_addr changes
buf_addr  out  AW  object buffer write address
buf_din   out  8   object buffer write data
buf_we    out  1   object buffer write strobe, one clk wide
busy      out  1   high from trigger accepted to bus released
done      out  1   one-clk pulse at end of a successful transfer
timeout   out  1   sticky abort flag; constant 0 without the optional feature

Behaviour:
- Reset (async, rst_n low): state IDLE; busrq, buf_we, busy, done, timeout = 0; dma_addr, buf_addr, buf_din = 0; pending flag cleared; dma_go edge register cleared.
- dma_go edge detection runs on every clk, not gated by pxl_cen. A rising edge sets the pending flag.
- IDLE: on pxl_cen with pending=1, clear pending, go to REQ, set busrq=1 and busy=1.
- REQ: on pxl_cen with busak_n=0, set dma_addr=0 and go to XFER. No write happens on this tick.
- XFER, on each pxl_cen with busak_n=0, at current dma_addr=n:
  - buf_addr<=n, buf_din<=dma_din, buf_we=1 for exactly one clk.
  - dma_addr<=n+1, wrapping modulo 2**AW.
  - When n=2**AW-1, go to REL after the write.
- XFER with busak_n=1 on pxl_cen: hold. No write, no increment; resume when the grant returns.
- REL: on next pxl_cen set busrq=0, busy=0, done=1 for one clk; go to IDLE.
- Timing: exactly 2**AW writes per transfer, in ascending address order starting at 0. busrq stays high for (grant wait) + 2**AW + 2 pxl_cen ticks.
- dma_go rising edge while busy: sets pending; a new transfer starts immediately after REL. Multiple edges while busy collapse into one.
- dma_go edge on the same clk as done: the edge is kept as pending, not lost.
- buf_we is never asserted outside XFER. dma_addr holds its last value while in IDLE.
- rst_n asserted mid-transfer: busrq drops asynchronously; the partial buffer contents are left as written.

Optional Feature:
Macro JTPANG_OBJDMA_TIMEOUT_EN.
- Defined: a grant-wait counter clears on entry to REQ and increments per pxl_cen in REQ. When it reaches TOUT, the block drops busrq, sets timeout=1 (sticky until reset), and returns to IDLE with no done pulse and no buffer writes. A later dma_go edge still retries.
- Not defined: REQ waits indefinitely, no counter logic is built, and timeout is tied to 0.

Test Plan:
- Basic copy: VRAM preset with byte[i]=i^8'h5A; pulse dma_go; grant 3 pxl_cen after busrq -> 512 buf_we pulses, addresses 0..511 in order, buf_din=i^8'h5A, one done pulse, then busrq=0.
- Grant dropped: release busak_n for 10 pxl_cen at dma_addr=100 -> no writes during the gap, resumes at 100, still exactly 512 writes with no duplicates.
- Re-trigger: two dma_go edges at dma_addr=50 -> second transfer starts right after the first done; 1024 writes total, two done pulses.
- Reset mid-transfer: rst_n low at dma_addr=300 -> busrq=0 within the same clk, all outputs 0; after release the block stays IDLE until a new dma_go.
- Timeout (macro defined, TOUT=16): busak_n held high -> busrq drops after 16 pxl_cen in REQ, timeout=1, no buf_we, no done.
- pxl_cen gating: hold pxl_cen low for 100 clk during XFER -> dma_addr, buf_we and state are frozen.
